// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the two-requester single-precision divider.
package fpdiv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, DONE} state_t;

  localparam int          BIAS      = 127;
  localparam int          DIV_ITERS = 25;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;

endpackage

// File: rtl/fpdiv_rr_arb.sv
// Two-way round-robin arbiter: pointer names the requester that wins a tie.
// Purely combinational; grants nothing unless the scheduler is idle.
module fpdiv_rr_arb (
  input  logic [1:0] req_valid,
  input  logic       pointer,
  input  logic       idle,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (idle) begin
      if (&req_valid) grant = pointer ? 2'b10 : 2'b01;
      else            grant = req_valid;
    end
  end

endmodule

// File: rtl/fpdiv_sched.sv
// Shared IEEE-754 single divider for two requesters; 27 edges accept->result, truncating.
// Optional macro FPDIV_SPECIAL_EN classifies NaN/inf/zero operands and skips the divide loop.
module fpdiv_sched
  import fpdiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] z
);

  state_t            state, nxt;
  logic              ptr;
  logic [1:0]        grant;
  logic              accept;
  logic [31:0]       a_q, b_q;
  logic              sign_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [24:0]       q_q;
  logic signed [9:0] diff_q;
  logic [4:0]        cnt_q;
  logic [31:0]       z_q;
  logic              id_q;

  // Reset must hold req_ready low even though the FSM already reads IDLE.
  fpdiv_rr_arb u_arb (
    .req_valid (req_valid),
    .pointer   (ptr),
    .idle      ((state == IDLE) && !rst),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign res_valid = (state == DONE);
  assign res_id    = id_q;
  assign z         = z_q;

`ifdef FPDIV_SPECIAL_EN
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        special;
  logic [31:0] special_z;

  // Denormals count as zero since the exponent field alone decides.
  always_comb begin
    a_zero    = (a_q[30:23] == 8'd0);
    b_zero    = (b_q[30:23] == 8'd0);
    a_inf     = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf     = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan     = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan     = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    special   = 1'b1;
    special_z = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      special_z = QNAN;
    else if (b_zero || a_inf)
      special_z = {a_q[31] ^ b_q[31], POS_INF[30:0]};
    else if (a_zero || b_inf)
      special_z = {a_q[31] ^ b_q[31], 31'd0};
    else
      special = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = LOAD;
`ifdef FPDIV_SPECIAL_EN
      LOAD: nxt = special ? DONE : DIV;
`else
      LOAD: nxt = DIV;
`endif
      DIV:  if (cnt_q == 5'(DIV_ITERS - 1)) nxt = NORM;
      NORM: nxt = DONE;
      DONE: if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  logic [24:0] rem_sub;
  logic        qbit;

  assign qbit    = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_q - {1'b0, mb_q};

  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  logic [31:0]       norm_z;

  // A leading quotient bit of 0 means ma < mb, so the result sits one binade lower.
  always_comb begin
    if (q_q[24]) begin
      mant_n = q_q[23:1];
      exp_n  = diff_q + 10'(BIAS);
    end else begin
      mant_n = q_q[22:0];
      exp_n  = diff_q + 10'(BIAS - 1);
    end
    if (exp_n >= 10'sd255)    norm_z = {sign_q, POS_INF[30:0]};
    else if (exp_n <= 10'sd0) norm_z = {sign_q, 31'd0};
    else                      norm_z = {sign_q, exp_n[7:0], mant_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      sign_q <= 1'b0;
      mb_q   <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      z_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q  <= grant[1] ? a1 : a0;
          b_q  <= grant[1] ? b1 : b0;
          id_q <= grant[1];
          ptr  <= ~grant[1];
        end
        LOAD: begin
          sign_q <= a_q[31] ^ b_q[31];
          rem_q  <= {1'b0, 1'b1, a_q[22:0]};
          mb_q   <= {1'b1, b_q[22:0]};
          diff_q <= $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]});
          q_q    <= '0;
          cnt_q  <= '0;
`ifdef FPDIV_SPECIAL_EN
          if (special) z_q <= special_z;
`endif
        end
        DIV: begin
          q_q   <= {q_q[23:0], qbit};
          rem_q <= qbit ? {rem_sub[23:0], 1'b0} : {rem_q[23:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: z_q <= norm_z;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_sched.sv
// Directed and randomized bench for fpdiv_sched against an integer-arithmetic quotient model.
module tb_fpdiv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [31:0] z;

  int   vectors     = 0;
  int   miscompares = 0;
  logic last_gnt;

  fpdiv_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
`ifdef FPDIV_SPECIAL_EN
    return (a[30:23] == 8'd0) || (b[30:23] == 8'd0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
`else
    return (a === 32'hx) && (b === 32'hx);
`endif
  endfunction

  // Quotient of the 24-bit significands scaled by 2^24, truncated; exponent by plain integer sums.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              e;
    longint unsigned ma, mb, q;
    logic [22:0]     mant;
    s = a[31] ^ b[31];
`ifdef FPDIV_SPECIAL_EN
    begin
      logic za, zb, ia, ib, na, nb;
      za = (a[30:23] == 0);
      zb = (b[30:23] == 0);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC0_0000;
      if (zb || ia) return {s, 31'h7F80_0000};
      if (za || ib) return {s, 31'd0};
    end
`endif
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    q  = (ma << 24) / mb;
    e  = int'({24'd0, a[30:23]}) - int'({24'd0, b[30:23]}) + 127;
    if (q >= 64'd16777216) mant = q[23:1];
    else begin
      mant = q[22:0];
      e    = e - 1;
    end
    if (e >= 255) return {s, 31'h7F80_0000};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], mant};
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'($urandom), 8'($urandom_range(200, 50)), 23'($urandom)};
  endfunction

  task automatic serve(input string tag, input int hold);
    int          n;
    int          lat;
    logic        g;
    logic        exp_id;
    logic        spec;
    logic [31:0] ez;
    if (req_valid == 2'b11) exp_id = ~last_gnt;
    else                    exp_id = req_valid[1];
    ez   = exp_id ? ref_div(a1, b1) : ref_div(a0, b0);
    spec = exp_id ? is_special(a1, b1) : is_special(a0, b0);
    n = 0;
    @(negedge clk);
    while (!(|(req_valid & req_ready)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".accept_wait"}, 32'(n < 100), 32'd1);
    chk({tag, ".grant"}, {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
    g        = req_ready[1];
    last_gnt = exp_id;
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) chk({tag, ".busy_ready"}, {30'd0, req_ready}, 32'd0);
    end while (!res_valid && lat < 60);
    if (spec) chk({tag, ".lat_special"}, 32'(lat <= 2), 32'd1);
    else      chk({tag, ".latency"}, 32'(lat), 32'd27);
    chk({tag, ".z"}, z, ez);
    chk({tag, ".id"}, 32'(res_id), 32'(exp_id));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_z"}, z, ez);
      chk({tag, ".hold_vld"}, 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({tag, ".release"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b0;
    a0 = 32'h40C0_0000; b0 = 32'h4000_0000;
    a1 = 32'h3F80_0000; b1 = 32'h4040_0000;
    last_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.z", z, 32'd0);
    chk("rst.res_id", 32'(res_id), 32'd0);
    rst = 1'b0;

    // Both valid from reset: 0 first, then 1, then a back-to-back 0.
    serve("rr0", 0);
    a0 = 32'h7F00_0000; b0 = 32'h0080_0000; req_valid[0] = 1'b1;
    serve("rr1", 0);
    serve("rr2_ovf", 5);
    a1 = 32'h0080_0000; b1 = 32'h7F00_0000; req_valid[1] = 1'b1;
    serve("uflow", 0);

`ifdef FPDIV_SPECIAL_EN
    a0 = 32'hBF80_0000; b0 = 32'h0000_0000; req_valid[0] = 1'b1;
    serve("sp_div0", 0);
    a0 = 32'h0000_0000; b0 = 32'h0000_0000; req_valid[0] = 1'b1;
    serve("sp_nan", 0);
`endif

    // Reset mid-divide: no result may surface afterwards.
    a0 = 32'h40C0_0000; b0 = 32'h4000_0000; req_valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (!(req_valid[0] && req_ready[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort.accept_wait", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    chk("abort.pre", 32'(res_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.rst_z", z, 32'd0);
    rst = 1'b0;
    last_gnt = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid) n++;
    end
    chk("abort.no_result", 32'(n), 32'd0);
    a1 = 32'hC2F6_0000; b1 = 32'h4120_0000; req_valid = 2'b11;
    serve("post_rst", 0);
    serve("post_rst1", 0);

    for (int k = 0; k < 24; k++) begin
      if (!req_valid[0] && $urandom_range(1, 0) == 1) begin
        a0 = rand_op(); b0 = rand_op(); req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && $urandom_range(1, 0) == 1) begin
        a1 = rand_op(); b1 = rand_op(); req_valid[1] = 1'b1;
      end
      if (req_valid == 2'b00) begin
        if (k % 2 == 0) begin a0 = rand_op(); b0 = rand_op(); req_valid[0] = 1'b1; end
        else            begin a1 = rand_op(); b1 = rand_op(); req_valid[1] = 1'b1; end
      end
      serve($sformatf("rnd%0d", k), $urandom_range(2, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
